// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite fetch controller: direction codes,
// default field widths and the packed layout of a full ROM address.
package sprite_pkg;

    localparam int SPR_ADDR_W     = 12;
    localparam int SPR_FRAME_BITS = 2;
    localparam int SPR_PIX_W      = 24;

    localparam logic [2:0] DIR_LEFT  = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_JUMP  = 3'd2;
    localparam logic [2:0] DIR_FALL  = 3'd3;
    localparam logic [2:0] DIR_STILL = 3'd4;

    typedef struct packed {
        logic                      player;
        logic [2:0]                dir;
        logic [SPR_FRAME_BITS-1:0] frame;
        logic [SPR_ADDR_W-1:0]     local_addr;
    } rom_addr_t;

    // Undefined direction codes collapse to STILL so the ROM never sees them.
    function automatic logic [2:0] dir_latch(input logic [3:0] dir);
        logic [2:0] res;
        case (dir)
            4'd0:    res = DIR_LEFT;
            4'd1:    res = DIR_RIGHT;
            4'd2:    res = DIR_JUMP;
            4'd3:    res = DIR_FALL;
            default: res = DIR_STILL;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// One character's animation sequencer: latched direction, frame divider
// and frame index, all advancing only on a vertical-sync tick.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAME_BITS = SPR_FRAME_BITS,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic [3:0]            dir,
    output logic [2:0]            dir_q,
    output logic [FRAME_BITS-1:0] frame_idx
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRAME_BITS-1:0] FRAME_LAST = FRAME_BITS'(NUM_FRAMES - 1);

    logic [2:0]            dir_q_r;
    logic [DIV_W-1:0]      div_r;
    logic [FRAME_BITS-1:0] frame_r;
    logic [2:0]            dir_in_s;
    logic [2:0]            dir_next_s;
    logic [DIV_W-1:0]      div_next_s;
    logic [FRAME_BITS-1:0] frame_next_s;

    // Next-state: a direction change beats any pending frame advance.
    always_comb begin
        dir_in_s     = dir_latch(dir);
        dir_next_s   = dir_q_r;
        div_next_s   = div_r;
        frame_next_s = frame_r;
        if (frame_tick) begin
            if (dir_in_s != dir_q_r) begin
                dir_next_s   = dir_in_s;
                div_next_s   = {DIV_W{1'b0}};
                frame_next_s = {FRAME_BITS{1'b0}};
            end else if (dir_q_r == DIR_STILL) begin
                div_next_s   = {DIV_W{1'b0}};
                frame_next_s = {FRAME_BITS{1'b0}};
            end else if (div_r == DIV_LAST) begin
                div_next_s   = {DIV_W{1'b0}};
                frame_next_s = (frame_r == FRAME_LAST) ? {FRAME_BITS{1'b0}}
                                                       : frame_r + FRAME_BITS'(1'b1);
            end else begin
                div_next_s   = div_r + DIV_W'(1'b1);
            end
        end else begin
            div_next_s   = div_r;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q_r <= DIR_STILL;
            div_r   <= {DIV_W{1'b0}};
            frame_r <= {FRAME_BITS{1'b0}};
        end else begin
            dir_q_r <= dir_next_s;
            div_r   <= div_next_s;
            frame_r <= frame_next_s;
        end
    end

    assign dir_q     = dir_q_r;
    assign frame_idx = frame_r;

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Shares one synchronous sprite ROM port between Fireboy and Watergirl,
// forms the full ROM address and steers returned pixels to their owner.
module sprite_fetch_ctrl
    import sprite_pkg::*;
#(
    parameter int ADDR_W     = SPR_ADDR_W,
    parameter int FRAME_BITS = SPR_FRAME_BITS,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_DIV  = 6,
    parameter int ROM_LAT    = 1,
    parameter int PIX_W      = SPR_PIX_W
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           frame_clk,
    input  logic [3:0]                     fb_dir,
    input  logic [3:0]                     wg_dir,
    input  logic                           fb_req,
    input  logic                           wg_req,
    input  logic [ADDR_W-1:0]              fb_addr,
    input  logic [ADDR_W-1:0]              wg_addr,
    output logic                           fb_ack,
    output logic                           wg_ack,
    output logic [ADDR_W+FRAME_BITS+3:0]   rom_addr,
    input  logic [PIX_W-1:0]               rom_data,
    output logic [PIX_W-1:0]               fb_pixel,
    output logic                           fb_pixel_valid,
    output logic [PIX_W-1:0]               wg_pixel,
    output logic                           wg_pixel_valid
);

    logic                  frame_clk_q_r;
    logic                  frame_tick_s;
    logic [2:0]            fb_dir_q_s;
    logic [2:0]            wg_dir_q_s;
    logic [FRAME_BITS-1:0] fb_frame_s;
    logic [FRAME_BITS-1:0] wg_frame_s;
    logic                  last_wg_r;
    logic                  grant_fb_s;
    logic                  grant_wg_s;
    logic [ROM_LAT-1:0]    tag_valid_r;
    logic [ROM_LAT-1:0]    tag_player_r;

    assign frame_tick_s = frame_clk & ~frame_clk_q_r;

    // Vertical-sync edge detector.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q_r <= 1'b0;
        end else begin
            frame_clk_q_r <= frame_clk;
        end
    end

    sprite_anim_seq #(
        .FRAME_BITS (FRAME_BITS),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_fb_seq (
        .clk        (Clk),
        .reset      (Reset),
        .frame_tick (frame_tick_s),
        .dir        (fb_dir),
        .dir_q      (fb_dir_q_s),
        .frame_idx  (fb_frame_s)
    );

    sprite_anim_seq #(
        .FRAME_BITS (FRAME_BITS),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_wg_seq (
        .clk        (Clk),
        .reset      (Reset),
        .frame_tick (frame_tick_s),
        .dir        (wg_dir),
        .dir_q      (wg_dir_q_s),
        .frame_idx  (wg_frame_s)
    );

    // Round-robin arbiter; a contested cycle goes to whoever lost last time.
    always_comb begin
        grant_fb_s = 1'b0;
        grant_wg_s = 1'b0;
        if (Reset) begin
            grant_fb_s = 1'b0;
        end else if (fb_req && wg_req) begin
            grant_fb_s = last_wg_r;
            grant_wg_s = ~last_wg_r;
        end else if (fb_req) begin
            grant_fb_s = 1'b1;
        end else if (wg_req) begin
            grant_wg_s = 1'b1;
        end else begin
            grant_fb_s = 1'b0;
        end
    end

    assign fb_ack = grant_fb_s;
    assign wg_ack = grant_wg_s;

    // Arbitration pointer and ROM address register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_wg_r <= 1'b1;
            rom_addr  <= {(ADDR_W + FRAME_BITS + 4){1'b0}};
        end else if (grant_fb_s) begin
            last_wg_r <= 1'b0;
            rom_addr  <= {1'b0, fb_dir_q_s, fb_frame_s, fb_addr};
        end else if (grant_wg_s) begin
            last_wg_r <= 1'b1;
            rom_addr  <= {1'b1, wg_dir_q_s, wg_frame_s, wg_addr};
        end else begin
            last_wg_r <= last_wg_r;
        end
    end

    // In-flight tag pipeline matching the ROM read latency.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tag_valid_r  <= {ROM_LAT{1'b0}};
            tag_player_r <= {ROM_LAT{1'b0}};
        end else begin
            tag_valid_r[0]  <= grant_fb_s | grant_wg_s;
            tag_player_r[0] <= grant_wg_s;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_valid_r[i]  <= tag_valid_r[i-1];
                tag_player_r[i] <= tag_player_r[i-1];
            end
        end
    end

    // Return steering: capture rom_data for the tagged player.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fb_pixel       <= {PIX_W{1'b0}};
            wg_pixel       <= {PIX_W{1'b0}};
            fb_pixel_valid <= 1'b0;
            wg_pixel_valid <= 1'b0;
        end else begin
            fb_pixel_valid <= 1'b0;
            wg_pixel_valid <= 1'b0;
            if (tag_valid_r[ROM_LAT-1]) begin
                if (tag_player_r[ROM_LAT-1]) begin
                    wg_pixel       <= rom_data;
                    wg_pixel_valid <= 1'b1;
                end else begin
                    fb_pixel       <= rom_data;
                    fb_pixel_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Self-checking bench for sprite_fetch_ctrl: directed scenarios followed by
// randomized traffic, all scored against a behavioural model.
module tb_sprite_fetch_ctrl;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [3:0]  fb_dir, wg_dir;
    logic        fb_req, wg_req;
    logic [11:0] fb_addr, wg_addr;
    logic        fb_ack, wg_ack;
    logic [17:0] rom_addr;
    logic [23:0] rom_data;
    logic [23:0] fb_pixel, wg_pixel;
    logic        fb_pixel_valid, wg_pixel_valid;

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_fn(input logic [17:0] a);
        return {a[5:0], a} ^ 24'h5A3C96;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    sprite_fetch_ctrl #(
        .ADDR_W(12), .FRAME_BITS(2), .NUM_FRAMES(4),
        .FRAME_DIV(6), .ROM_LAT(1), .PIX_W(24)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .fb_dir(fb_dir), .wg_dir(wg_dir),
        .fb_req(fb_req), .wg_req(wg_req),
        .fb_addr(fb_addr), .wg_addr(wg_addr),
        .fb_ack(fb_ack), .wg_ack(wg_ack),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_pixel(fb_pixel), .fb_pixel_valid(fb_pixel_valid),
        .wg_pixel(wg_pixel), .wg_pixel_valid(wg_pixel_valid)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: per-character direction and tick count since the
    // last direction change; the frame is derived arithmetically from it.
    typedef struct {
        int          due;
        bit          player;
        logic [23:0] pix;
    } ret_t;

    int          m_dir[2];
    int          m_ticks[2];
    bit          m_fclk_q;
    bit          m_last_wg;
    logic [17:0] m_rom_addr;
    logic [23:0] m_pix[2];
    ret_t        ret_q[$];
    int          cyc;
    bit          auto_mode, hold_req;
    bit          dut_ack[2];
    int          cnt_ack[2], cnt_v[2];

    function automatic void model_reset();
        m_dir[0] = 4; m_dir[1] = 4;
        m_ticks[0] = 0; m_ticks[1] = 0;
        m_fclk_q = 1'b0;
        m_last_wg = 1'b1;
        m_rom_addr = 18'h0;
        m_pix[0] = 24'h0; m_pix[1] = 24'h0;
        ret_q.delete();
    endfunction

    function automatic int m_frame(int p);
        if (m_dir[p] == 4) return 0;
        return (m_ticks[p] / 6) % 4;
    endfunction

    function automatic logic [17:0] m_addr(bit p, logic [11:0] la);
        rom_addr_t r;
        r.player     = p;
        r.dir        = 3'(m_dir[p]);
        r.frame      = 2'(m_frame(p));
        r.local_addr = la;
        return r;
    endfunction

    task automatic run_cycle();
        bit          ev[2];
        bit          g[2];
        int          i, nd;
        bit          p;
        logic [17:0] a;
        ret_t        r;
        int          dirs[2];
        ev[0] = 1'b0; ev[1] = 1'b0;
        i = 0;
        while (i < ret_q.size()) begin
            if (ret_q[i].due == cyc) begin
                ev[ret_q[i].player] = 1'b1;
                m_pix[ret_q[i].player] = ret_q[i].pix;
                ret_q.delete(i);
            end else begin
                i++;
            end
        end
        check_eq("rom_addr", rom_addr, m_rom_addr);
        check_eq("fb_pixel_valid", fb_pixel_valid, ev[0]);
        check_eq("fb_pixel", fb_pixel, m_pix[0]);
        check_eq("wg_pixel_valid", wg_pixel_valid, ev[1]);
        check_eq("wg_pixel", wg_pixel, m_pix[1]);
        if (fb_pixel_valid === 1'b1) cnt_v[0]++;
        if (wg_pixel_valid === 1'b1) cnt_v[1]++;
        #1;
        g[0] = 1'b0; g[1] = 1'b0;
        if (!Reset) begin
            if (fb_req && wg_req) g[m_last_wg ? 0 : 1] = 1'b1;
            else if (fb_req)      g[0] = 1'b1;
            else if (wg_req)      g[1] = 1'b1;
        end
        check_eq("fb_ack", fb_ack, g[0]);
        check_eq("wg_ack", wg_ack, g[1]);
        dut_ack[0] = (fb_ack === 1'b1);
        dut_ack[1] = (wg_ack === 1'b1);
        if (dut_ack[0]) cnt_ack[0]++;
        if (dut_ack[1]) cnt_ack[1]++;
        if (Reset) begin
            model_reset();
        end else begin
            if (g[0] || g[1]) begin
                p = g[1];
                a = m_addr(p, p ? wg_addr : fb_addr);
                m_rom_addr = a;
                r.due = cyc + 2; r.player = p; r.pix = rom_fn(a);
                ret_q.push_back(r);
                m_last_wg = p;
            end
            dirs[0] = int'(fb_dir); dirs[1] = int'(wg_dir);
            if (frame_clk && !m_fclk_q) begin
                for (int k = 0; k < 2; k++) begin
                    nd = (dirs[k] > 4) ? 4 : dirs[k];
                    if (nd != m_dir[k]) begin
                        m_dir[k] = nd;
                        m_ticks[k] = 0;
                    end else if (m_dir[k] != 4) begin
                        m_ticks[k]++;
                    end
                end
            end
            m_fclk_q = frame_clk;
        end
        @(posedge Clk);
        #1;
        cyc++;
        if (g[0] && !hold_req) fb_req = 1'b0;
        if (g[1] && !hold_req) wg_req = 1'b0;
        if (auto_mode) begin
            if (!fb_req) begin fb_req = ($urandom_range(0, 99) < 60); fb_addr = 12'($urandom); end
            if (!wg_req) begin wg_req = ($urandom_range(0, 99) < 60); wg_addr = 12'($urandom); end
            if ($urandom_range(0, 99) < 4) fb_dir = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 4) wg_dir = 4'($urandom_range(0, 15));
            frame_clk = 1'($urandom_range(0, 1));
            Reset = ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            frame_clk = 1'b1; run_cycle();
            frame_clk = 1'b0; run_cycle();
        end
    endtask

    task automatic fetch_fb(input string tag, input logic [11:0] la, input logic [17:0] exp);
        fb_addr = la;
        fb_req = 1'b1;
        run_cycle();
        check_eq(tag, rom_addr, exp);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0;
        fb_dir = 4'd4; wg_dir = 4'd4;
        fb_req = 1'b0; wg_req = 1'b0;
        fb_addr = 12'h0; wg_addr = 12'h0;
        auto_mode = 1'b0; hold_req = 1'b0;
        cnt_ack[0] = 0; cnt_ack[1] = 0; cnt_v[0] = 0; cnt_v[1] = 0;
        model_reset();
        cyc = 0;
        @(posedge Clk); #1;
        run_cycle();
        run_cycle();
        Reset = 1'b0;

        // Contested first request after reset goes to Fireboy.
        fb_req = 1'b1; wg_req = 1'b1;
        fb_addr = 12'h123; wg_addr = 12'h045;
        run_cycle();
        check_eq("t1_fb_ack_c0", dut_ack[0], 1'b1);
        check_eq("t1_rom_addr_fb", rom_addr, 18'h10123);
        run_cycle();
        check_eq("t1_wg_ack_c1", dut_ack[1], 1'b1);
        check_eq("t1_rom_addr_wg", rom_addr, 18'h30045);
        check_eq("t1_fb_valid_c2", fb_pixel_valid, 1'b1);
        check_eq("t1_fb_pixel_c2", fb_pixel, rom_fn(18'h10123));
        run_cycle();
        check_eq("t1_wg_valid_c3", wg_pixel_valid, 1'b1);
        check_eq("t1_wg_pixel_c3", wg_pixel, rom_fn(18'h30045));

        // Animation stepping and wrap.
        fb_dir = 4'd1;
        tick_n(1);
        fetch_fb("t2_frame0", 12'h7FF, 18'h047FF);
        tick_n(6);
        fetch_fb("t2_frame1", 12'h7FF, 18'h057FF);
        tick_n(12);
        fetch_fb("t2_frame3", 12'h7FF, 18'h077FF);
        tick_n(6);
        fetch_fb("t2_wrap", 12'h7FF, 18'h047FF);

        // Direction change on the advancing tick wins.
        tick_n(5);
        fb_dir = 4'd2;
        tick_n(1);
        fetch_fb("t3_change", 12'h7FF, 18'h087FF);

        // Out-of-range direction latches as STILL.
        fb_dir = 4'd9;
        tick_n(21);
        fetch_fb("t4_still", 12'h7FF, 18'h107FF);

        // Continuous dual requests alternate.
        Reset = 1'b1; run_cycle(); Reset = 1'b0;
        cnt_ack[0] = 0; cnt_ack[1] = 0; cnt_v[0] = 0; cnt_v[1] = 0;
        fb_req = 1'b1; wg_req = 1'b1; hold_req = 1'b1;
        repeat (8) run_cycle();
        hold_req = 1'b0; fb_req = 1'b0; wg_req = 1'b0;
        repeat (3) run_cycle();
        check_eq("t5_fb_acks", cnt_ack[0], 4);
        check_eq("t5_wg_acks", cnt_ack[1], 4);
        check_eq("t5_fb_valids", cnt_v[0], 4);
        check_eq("t5_wg_valids", cnt_v[1], 4);

        // Reset right after a grant drops the in-flight read.
        fb_req = 1'b1; fb_addr = 12'h0AB;
        run_cycle();
        Reset = 1'b1;
        run_cycle();
        check_eq("t6_rom_addr", rom_addr, 18'h0);
        check_eq("t6_fb_valid", fb_pixel_valid, 1'b0);
        check_eq("t6_fb_pixel", fb_pixel, 24'h0);
        check_eq("t6_wg_valid", wg_pixel_valid, 1'b0);
        check_eq("t6_wg_pixel", wg_pixel, 24'h0);
        Reset = 1'b0;
        cnt_v[0] = 0; cnt_v[1] = 0;
        repeat (3) run_cycle();
        check_eq("t6_no_late_valid", cnt_v[0] + cnt_v[1], 0);

        // Randomized traffic.
        auto_mode = 1'b1;
        repeat (1500) run_cycle();
        auto_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
